// File: rtl/systolic_feeder.sv
// Skewed activation feeder for a systolic PE column: accepts N-lane vectors over valid/ready,
// issues a one-cycle accumulator clear per tile and delays lane i by i extra cycles.
module systolic_feeder #(
    parameter  int N     = 3,
    parameter  int W     = 8,
    parameter  int MAX_K = 255,
    localparam int KW    = $clog2(MAX_K + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*W-1:0]  s_data,
    output logic            clear,
    output logic [N*W-1:0]  a_out,
    output logic [N-1:0]    valid_out,
    output logic            busy,
    output logic            done
);

    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   cnt_q;
    logic [FW-1:0]   flush_q;
    logic            s_ready_q;
    logic            clear_q;
    logic            busy_q;
    logic            done_q;
    logic            accept_d;
    logic [KW-1:0]   k_eff_d;

    assign accept_d = s_valid & s_ready_q;

    // Saturation is only needed when the k_len port can express values above MAX_K.
    generate
        if (MAX_K < (1 << KW) - 1) begin : g_clamp
            assign k_eff_d = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;
        end else begin : g_noclamp
            assign k_eff_d = k_len;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
            s_ready_q <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (k_eff_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q     <= k_eff_d;
                            cnt_q   <= '0;
                            clear_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    clear_q   <= 1'b0;
                    s_ready_q <= 1'b1;
                    state_q   <= S_FEED;
                end
                S_FEED: begin
                    if (accept_d) begin
                        cnt_q <= cnt_q + KW'(1);
                        if (cnt_q + KW'(1) == k_q) begin
                            s_ready_q <= 1'b0;
                            flush_q   <= '0;
                            state_q   <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Lane N-1 lags the last accepted beat by N cycles.
                    if (flush_q == FW'(N - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        flush_q <= flush_q + FW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign clear   = clear_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Lane gi is a (gi+1)-deep shift register; bubbles enter as zero data with valid low.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [W-1:0] data_q [0:gi];
            logic [gi:0]  vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int s = 0; s <= gi; s++) begin
                        data_q[s] <= '0;
                    end
                end else begin
                    vld_q[0]  <= accept_d;
                    data_q[0] <= accept_d ? s_data[gi*W +: W] : '0;
                    for (int s = 1; s <= gi; s++) begin
                        vld_q[s]  <= vld_q[s-1];
                        data_q[s] <= data_q[s-1];
                    end
                end
            end

            assign valid_out[gi]     = vld_q[gi];
            assign a_out[gi*W +: W]  = vld_q[gi] ? data_q[gi] : '0;
        end
    endgenerate

endmodule
